// File: rtl/psum_requant_drain.sv
// Drains column-skewed partial sums from the bottom of the systolic array, realigns them into rows,
// applies bias, rounding shift, optional ReLU and saturation, and buffers rows in a show-ahead FIFO.
module psum_requant_drain #(
    parameter int N_COLS     = 8,
    parameter int DATA_WIDTH = 22,
    parameter int PORT_WIDTH = 8,
    parameter int COL_SKEW   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           psum_valid_in,
    input  logic [N_COLS*DATA_WIDTH-1:0]   psum_in,
    input  logic                           cfg_bias_wr,
    input  logic [$clog2(N_COLS)-1:0]      cfg_bias_idx,
    input  logic [DATA_WIDTH-1:0]          cfg_bias_data,
    input  logic [4:0]                     cfg_shift,
    input  logic                           cfg_relu_en,
    input  logic                           cfg_clr_ovf,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_COLS*PORT_WIDTH-1:0]   out_data,
    output logic                           overflow
);

    localparam int D     = (N_COLS - 1) * COL_SKEW;
    localparam int W1    = DATA_WIDTH + 1;
    localparam int W2    = DATA_WIDTH + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [W2-1:0] ONE    = {{(W2-1){1'b0}}, 1'b1};
    localparam logic signed [W2-1:0] SAT_HI = W2'(2**(PORT_WIDTH-1) - 1);
    localparam logic signed [W2-1:0] SAT_LO = W2'(-(2**(PORT_WIDTH-1)));

    // ---------------- de-skew ----------------
    logic [DATA_WIDTH-1:0] aligned [N_COLS];
    logic [D-1:0]          vld_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[D-2:0], psum_valid_in};
    end

    // Earlier columns arrive earlier, so they get the longest delay lines.
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        localparam int L = (N_COLS - 1 - c) * COL_SKEW;
        if (L == 0) begin : g_pass
            assign aligned[c] = psum_in[c*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly [L];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < L; k++) dly[k] <= '0;
                end else begin
                    dly[0] <= psum_in[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < L; k++) dly[k] <= dly[k-1];
                end
            end
            assign aligned[c] = dly[L-1];
        end
    end

    // ---------------- stage 1: bias ----------------
    logic [DATA_WIDTH-1:0] bias_reg [N_COLS];
    logic signed [W1-1:0]  s1       [N_COLS];
    logic                  s1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int c = 0; c < N_COLS; c++) begin
                bias_reg[c] <= '0;
                s1[c]       <= '0;
            end
        end else begin
            if (cfg_bias_wr) bias_reg[cfg_bias_idx] <= cfg_bias_data;
            s1_valid <= vld_sr[D-1];
            for (int c = 0; c < N_COLS; c++)
                s1[c] <= $signed({aligned[c][DATA_WIDTH-1], aligned[c]})
                       + $signed({bias_reg[c][DATA_WIDTH-1], bias_reg[c]});
        end
    end

    // ---------------- stage 2: round, shift, relu, saturate ----------------
    logic [N_COLS*PORT_WIDTH-1:0] s2_next;
    logic [N_COLS*PORT_WIDTH-1:0] s2_row;
    logic                         s2_valid;

    always_comb begin
        logic signed [W2-1:0] ext;
        logic signed [W2-1:0] rnd;
        logic signed [W2-1:0] r;
        s2_next = '0;
        for (int c = 0; c < N_COLS; c++) begin
            ext = {s1[c][W1-1], s1[c]};
            rnd = (cfg_shift == 5'd0) ? '0 : (ONE << (cfg_shift - 5'd1));
            r   = (ext + rnd) >>> cfg_shift;
            if (cfg_relu_en && r[W2-1]) r = '0;
            if (r > SAT_HI)      s2_next[c*PORT_WIDTH +: PORT_WIDTH] = SAT_HI[PORT_WIDTH-1:0];
            else if (r < SAT_LO) s2_next[c*PORT_WIDTH +: PORT_WIDTH] = SAT_LO[PORT_WIDTH-1:0];
            else                 s2_next[c*PORT_WIDTH +: PORT_WIDTH] = r[PORT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_row   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_row   <= s2_next;
        end
    end

    // ---------------- output FIFO ----------------
    // Handshake: a row transfers on any clock edge where out_valid && out_ready; out_valid and
    // out_data hold steady while out_ready is low. The upstream side never stalls, so a row
    // arriving at a full FIFO with no pop is dropped and flagged in overflow.
    logic [N_COLS*PORT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         pop;
    logic                         push_ok;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push_ok   = s2_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= s2_row;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A drop this cycle wins over a clear request.
            if (s2_valid && !push_ok) overflow <= 1'b1;
            else if (cfg_clr_ovf)     overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_requant_drain.sv
// Scoreboard bench for psum_requant_drain: skewed row driver, expected-row queue, per-feature tasks.
module tb_psum_requant_drain;

    localparam int N    = 8;
    localparam int DW   = 22;
    localparam int PW   = 8;
    localparam int SK   = 4;
    localparam int FD   = 4;
    localparam int LAT  = (N - 1) * SK + 3;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psum_valid_in;
    logic [N*DW-1:0] psum_in;
    logic          cfg_bias_wr;
    logic [2:0]    cfg_bias_idx;
    logic [DW-1:0] cfg_bias_data;
    logic [4:0]    cfg_shift;
    logic          cfg_relu_en;
    logic          cfg_clr_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [N*PW-1:0] out_data;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic            iss_v   [MAXC];
    logic [N*DW-1:0] iss_row [MAXC];
    logic [N*PW-1:0] exp_q[$];
    longint          tb_bias [N];

    psum_requant_drain #(
        .N_COLS(N), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .COL_SKEW(SK), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .psum_valid_in(psum_valid_in), .psum_in(psum_in),
        .cfg_bias_wr(cfg_bias_wr), .cfg_bias_idx(cfg_bias_idx), .cfg_bias_data(cfg_bias_data),
        .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en), .cfg_clr_ovf(cfg_clr_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .overflow(overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N*PW-1:0] model_row(input logic [N*DW-1:0] row);
        logic [N*PW-1:0] res;
        logic [DW-1:0]   f;
        longint          s;
        longint          r;
        res = '0;
        for (int c = 0; c < N; c++) begin
            f = row[c*DW +: DW];
            s = longint'($signed(f)) + tb_bias[c];
            if (cfg_shift == 5'd0) r = s;
            else r = (s + (longint'(1) << (cfg_shift - 5'd1))) >>> cfg_shift;
            if (cfg_relu_en && r < 0) r = 0;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            res[c*PW +: PW] = PW'(r);
        end
        return res;
    endfunction

    // ---------------- driver / monitor ----------------
    // Applies this cycle's skewed column data, checks a popped row, then advances one clock.
    task automatic step();
        logic [N*PW-1:0] e;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got cycle %0d required below %0d", cyc, MAXC - 1);
            $fatal(1);
        end
        psum_valid_in = iss_v[cyc];
        for (int c = 0; c < N; c++) begin
            int src;
            src = cyc - c * SK;
            if (src >= 0 && iss_v[src]) psum_in[c*DW +: DW] = iss_row[src][c*DW +: DW];
            else                        psum_in[c*DW +: DW] = DW'($urandom);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_row: got %h required no row", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL row_data: got %h required %h", out_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic schedule(input int at, input logic [N*DW-1:0] row,
                            input logic [N*PW-1:0] e, input bit keep);
        iss_v[at]   = 1'b1;
        iss_row[at] = row;
        if (keep) exp_q.push_back(e);
    endtask

    task automatic write_bias(input int idx, input longint val);
        cfg_bias_wr   = 1'b1;
        cfg_bias_idx  = 3'(idx);
        cfg_bias_data = DW'(val);
        tb_bias[idx]  = longint'($signed(cfg_bias_data));
        step();
        cfg_bias_wr = 1'b0;
    endtask

    task automatic set_all_bias(input longint val);
        for (int c = 0; c < N; c++) write_bias(c, val);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d rows pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h required 0", out_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", overflow); end
    endtask

    task automatic test_single_row();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        set_all_bias(0);
        cfg_shift = 5'd0; cfg_relu_en = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < N; c++) row[c*DW +: DW] = DW'(c - 3);
        e = 64'h04030201_00FFFEFD;
        schedule(cyc, row, e, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: got %b required 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid: got %b required 1", out_valid); end
        checks++; if (out_data !== e) begin failures++; $display("FAIL single_row_data: got %h required %h", out_data, e); end
        drain(5);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_row_empty: got %b required 0", out_valid); end
    endtask

    task automatic test_arith();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        // bias -40, shift 4: (1000+16c-40+8)>>4 = 60+c
        set_all_bias(-40);
        cfg_shift = 5'd4;
        for (int c = 0; c < N; c++) begin
            row[c*DW +: DW] = DW'(1000 + 16 * c);
            e[c*PW +: PW]   = PW'(60 + c);
        end
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
        // shift 1 rounds half up: -25 -> -12
        set_all_bias(0);
        cfg_shift = 5'd1;
        for (int c = 0; c < N; c++) begin
            row[c*DW +: DW] = DW'(-25 - 2 * c);
            e[c*PW +: PW]   = PW'(-12 - c);
        end
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
        // shift 2 with saturation at both ends
        cfg_shift = 5'd2;
        for (int c = 0; c < N; c++) begin
            row[c*DW +: DW] = DW'(5000 - 700 * c);
            e[c*PW +: PW]   = 8'd127;
        end
        row[6*DW +: DW] = DW'(-5000);
        e[6*PW +: PW]   = 8'h80;
        e[7*PW +: PW]   = 8'd25;
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
    endtask

    task automatic test_relu();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        cfg_shift = 5'd0;
        for (int c = 0; c < N; c++) row[c*DW +: DW] = DW'(-300 + 100 * c);
        cfg_relu_en = 1'b1;
        e = {8'd127, 8'd127, 8'd127, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
        cfg_relu_en = 1'b0;
        e = {8'd127, 8'd127, 8'd127, 8'd100, 8'd0, 8'h9C, 8'h80, 8'h80};
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] row;
        int t0;
        int shifts [3] = '{0, 5, 13};
        for (int m = 0; m < 3; m++) begin
            cfg_shift   = 5'(shifts[m]);
            cfg_relu_en = (m == 1);
            for (int c = 0; c < N; c++) write_bias(c, longint'(int'($urandom_range(0, 1000)) - 500));
            t0 = cyc;
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < N; c++) begin
                    if (m == 2) row[c*DW +: DW] = DW'($urandom);
                    else        row[c*DW +: DW] = DW'(int'($urandom_range(0, 600)) - 300);
                end
                schedule(t0 + i, row, model_row(row), 1'b1);
            end
            drain(LAT + 30);
            checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b required 0", overflow); end
        end
        set_all_bias(0);
        cfg_shift = 5'd0; cfg_relu_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        logic [N*PW-1:0] e0;
        int t0;
        out_ready = 1'b0;
        t0 = cyc;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++) begin
                row[c*DW +: DW] = DW'(10 * r + c);
                e[c*PW +: PW]   = PW'(10 * r + c);
            end
            if (r == 0) e0 = e;
            schedule(t0 + r, row, e, r < FD);
        end
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k == LAT + 3) begin
                checks++;
                if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop: got %b required 0", overflow); end
            end
            if (k == LAT + 4) begin
                checks++;
                if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_on_drop: got %b required 1", overflow); end
            end
            if (k >= LAT + 5 && k <= LAT + 9) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== e0) begin
                    failures++;
                    $display("FAIL hold_stable: got v=%b %h required v=1 %h", out_valid, out_data, e0);
                end
            end
        end
        drain(10);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_only_four: got %b required 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        cfg_clr_ovf = 1'b1;
        step();
        cfg_clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b required 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        int t0;
        t0 = cyc;
        for (int r = 0; r < FD + 1; r++) begin
            for (int c = 0; c < N; c++) begin
                row[c*DW +: DW] = DW'(20 * r + c);
                e[c*PW +: PW]   = PW'(20 * r + c);
            end
            schedule(t0 + r, row, e, 1'b1);
        end
        // Pop exactly in the cycle the fifth row is pushed into the full FIFO.
        while (cyc < t0 + 40) begin
            out_ready = (cyc == t0 + FD + LAT - 1);
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_pp_valid: got %b required 1", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pp_ovf: got %b required 0", overflow); end
        drain(10);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_pp_empty: got %b required 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        logic [N*DW-1:0] row;
        logic [N*PW-1:0] e;
        int seen;
        set_all_bias(50);
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) row[c*DW +: DW] = DW'(1);
        for (int r = 0; r < 3; r++) schedule(cyc + r, row, '0, 1'b0);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) tb_bias[c] = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b required 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf: got %b required 0", overflow); end
        seen = 0;
        repeat (LAT + 20) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_stale_rows: got %0d required 0", seen); end
        for (int c = 0; c < N; c++) begin
            row[c*DW +: DW] = DW'(7 + c);
            e[c*PW +: PW]   = PW'(7 + c);
        end
        schedule(cyc, row, e, 1'b1);
        drain(LAT + 10);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < MAXC; i++) begin
            iss_v[i]   = 1'b0;
            iss_row[i] = '0;
        end
        for (int c = 0; c < N; c++) tb_bias[c] = 0;
        rst_n = 1'b0; psum_valid_in = 1'b0; psum_in = '0;
        cfg_bias_wr = 1'b0; cfg_bias_idx = '0; cfg_bias_data = '0;
        cfg_shift = 5'd0; cfg_relu_en = 1'b0; cfg_clr_ovf = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single_row();
        test_arith();
        test_relu();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
